rcb_frl_rx_byte_align: RTL and testbench

//   Receive-side byte aligner for the Fast Radio Link. Takes raw 8-bit words from the 1:8 input

---
 rtl/rcb_frl_rx_byte_align_if.sv | 30 +++
 rtl/rcb_frl_rx_byte_align.sv | 162 ++++++++++++++++
 tb/tb_rcb_frl_rx_byte_align.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rcb_frl_rx_byte_align_if.sv
`default_nettype none
// ============================================================================
// Module      : rcb_frl_rx_byte_align_if
// Description : Word bus between the input deserializer, the FRL RX byte
//               aligner and the frame decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface rcb_frl_rx_byte_align_if;
  logic [7:0] din;
  logic       din_en;
  logic       resync;
  logic [7:0] dout;
  logic       dout_valid;
  logic       locked;
  logic [2:0] offset;
  logic [7:0] loss_cnt;

  // Source side: drives raw words and control, observes aligned output
  modport master (
    output din, din_en, resync,
    input  dout, dout_valid, locked, offset, loss_cnt
  );

  // Aligner side
  modport slave (
    input  din, din_en, resync,
    output dout, dout_valid, locked, offset, loss_cnt
  );
endinterface
`default_nettype wire

// File: rtl/rcb_frl_rx_byte_align.sv
`default_nettype none
// ============================================================================
// Module      : rcb_frl_rx_byte_align
// Description : FRL receive byte aligner. Finds the byte boundary in the raw
//               deserialized word stream using a repeating training byte and
//               then emits aligned bytes continuously (din[7] = earliest bit).
// Revision    : 1.0 - initial release
// ============================================================================
module rcb_frl_rx_byte_align #(
  parameter logic [7:0]  TRAIN_PATTERN = 8'hF0,
  parameter int unsigned LOCK_COUNT    = 16,
  parameter int unsigned RELOCK_COUNT  = 8
) (
  input wire clk,
  input wire rst_n,
  rcb_frl_rx_byte_align_if.slave bus
);

  localparam logic [1:0] ST_SEARCH = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam logic [7:0] LOCK_LIMIT   = 8'(LOCK_COUNT);
  localparam logic [7:0] RELOCK_LIMIT = 8'(RELOCK_COUNT);

  logic [7:0]  r_din_q;
  logic [7:0]  r_din_qq;
  logic [7:0]  r_dout;
  logic        r_dout_valid;
  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [7:0]  r_cnt;
  logic [7:0]  w_cnt_nxt;
  logic [2:0]  r_offset;
  logic [2:0]  w_offset_nxt;
  logic [7:0]  r_loss_cnt;
  logic [7:0]  w_loss_nxt;
  logic [7:0]  w_loss_inc;
  logic [15:0] w_win;
  logic [7:0]  w_byte [8];
  logic [7:0]  w_hit;
  logic [2:0]  w_first_hit;
  logic        w_any_hit;
  logic        w_hit_cur;
  logic        w_hit_other;

  // Extract the 8 candidate bytes from the two-word window and flag training hits
  always_comb begin
    w_win       = {r_din_qq, r_din_q};
    w_first_hit = 3'd0;
    for (int k = 0; k < 8; k++) begin
      w_byte[k] = w_win[15-k -: 8];
      w_hit[k]  = (w_byte[k] == TRAIN_PATTERN);
    end
    // Scan downwards so the lowest hit offset is the one that sticks
    for (int k = 7; k >= 0; k--) begin
      if (w_hit[k]) begin
        w_first_hit = 3'(k);
      end
    end
  end

  assign w_any_hit   = |w_hit;
  assign w_hit_cur   = w_hit[r_offset];
  assign w_hit_other = w_any_hit & ~w_hit_cur;
  assign w_loss_inc  = (r_loss_cnt == 8'hFF) ? r_loss_cnt : r_loss_cnt + 8'd1;

  // Next-state logic: search, verify the candidate offset, then watch for drift
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_offset_nxt = r_offset;
    w_loss_nxt   = r_loss_cnt;
    if (bus.resync) begin
      w_state_nxt = ST_SEARCH;
      w_cnt_nxt   = 8'd0;
      if (r_state == ST_LOCKED) begin
        w_loss_nxt = w_loss_inc;
      end
    end else if (bus.din_en) begin
      case (r_state)
        ST_SEARCH: begin
          if (w_any_hit) begin
            w_offset_nxt = w_first_hit;
            w_cnt_nxt    = 8'd1;
            w_state_nxt  = ST_VERIFY;
          end
        end
        ST_VERIFY: begin
          if (!w_hit_cur) begin
            w_state_nxt = ST_SEARCH;
            w_cnt_nxt   = 8'd0;
          end else if (r_cnt + 8'd1 == LOCK_LIMIT) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = r_cnt + 8'd1;
          end
        end
        ST_LOCKED: begin
          // Only training seen consistently at another offset counts as drift
          if (w_hit_other) begin
            if (r_cnt + 8'd1 == RELOCK_LIMIT) begin
              w_state_nxt = ST_SEARCH;
              w_cnt_nxt   = 8'd0;
              w_loss_nxt  = w_loss_inc;
            end else begin
              w_cnt_nxt = r_cnt + 8'd1;
            end
          end else begin
            w_cnt_nxt = 8'd0;
          end
        end
        default: begin
          w_state_nxt = ST_SEARCH;
          w_cnt_nxt   = 8'd0;
        end
      endcase
    end
  end

  // State register and control outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_SEARCH;
      r_cnt        <= 8'd0;
      r_offset     <= 3'd0;
      r_loss_cnt   <= 8'd0;
      r_dout_valid <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_offset     <= w_offset_nxt;
      r_loss_cnt   <= w_loss_nxt;
      r_dout_valid <= bus.din_en && (w_state_nxt == ST_LOCKED);
    end
  end

  // Word pipeline and aligned byte selection, advancing only on enabled words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_din_q  <= 8'd0;
      r_din_qq <= 8'd0;
      r_dout   <= 8'd0;
    end else if (bus.din_en) begin
      r_din_qq <= r_din_q;
      r_din_q  <= bus.din;
      r_dout   <= w_byte[r_offset];
    end
  end

  // Drive the bus outputs from registered state
  always_comb begin
    bus.dout       = r_dout;
    bus.dout_valid = r_dout_valid;
    bus.locked     = (r_state == ST_LOCKED);
    bus.offset     = r_offset;
    bus.loss_cnt   = r_loss_cnt;
  end

endmodule
`default_nettype wire

// File: tb/tb_rcb_frl_rx_byte_align.sv
`default_nettype none
// ============================================================================
// Module      : tb_rcb_frl_rx_byte_align
// Description : Self-checking bench for the FRL RX byte aligner. A bit-level
//               TX stream with an adjustable bit delay feeds the DUT; a
//               behavioural model predicts every output each cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rcb_frl_rx_byte_align;

  localparam int         LOCKN   = 16;
  localparam int         RELOCKN = 8;
  localparam logic [7:0] PAT     = 8'hF0;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  rcb_frl_rx_byte_align_if bus ();

  rcb_frl_rx_byte_align #(
    .TRAIN_PATTERN(PAT),
    .LOCK_COUNT   (LOCKN),
    .RELOCK_COUNT (RELOCKN)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total = 0;
  int bad   = 0;
  bit chk_on = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_old, m_new;          // last two received words, oldest first
  int m_dout, m_valid, m_off, m_loss;
  bit m_locked, m_confirm;
  int run, slip, first, off_before;
  bit hitv [8];

  // Byte starting k bits into the two-word stream
  function automatic int pick(input int older, input int newer, input int k);
    int stream;
    stream = (older << 8) | newer;
    return (stream >> (8 - k)) & 255;
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= 255) ? 255 : v + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_old = 0; m_new = 0; m_dout = 0; m_valid = 0; m_off = 0; m_loss = 0;
      m_locked = 0; m_confirm = 0; run = 0; slip = 0;
    end else begin
      first = -1;
      for (int k = 7; k >= 0; k--) begin
        hitv[k] = (pick(m_old, m_new, k) == int'(PAT));
        if (hitv[k]) first = k;
      end
      off_before = m_off;
      if (bus.resync) begin
        if (m_locked) m_loss = sat_inc(m_loss);
        m_locked = 0; m_confirm = 0; run = 0; slip = 0; m_valid = 0;
      end else if (bus.din_en) begin
        if (m_locked) begin
          if (!hitv[m_off] && first >= 0) begin
            slip++;
            if (slip == RELOCKN) begin
              m_locked = 0; slip = 0; m_loss = sat_inc(m_loss);
            end
          end else begin
            slip = 0;
          end
        end else if (m_confirm) begin
          if (hitv[m_off]) begin
            run++;
            if (run == LOCKN) begin
              m_locked = 1; m_confirm = 0; run = 0; slip = 0;
            end
          end else begin
            m_confirm = 0; run = 0;
          end
        end else if (first >= 0) begin
          m_off = first; m_confirm = 1; run = 1;
        end
        m_valid = m_locked ? 1 : 0;
      end else begin
        m_valid = 0;
      end
      if (bus.din_en) begin
        m_dout = pick(m_old, m_new, off_before);
        m_old  = m_new;
        m_new  = int'(bus.din);
      end
    end
  end

  // Compare every output against the model between clock edges
  always @(negedge clk) begin
    if (chk_on && rst_n) begin
      check("dout",       int'(bus.dout),       m_dout);
      check("dout_valid", int'(bus.dout_valid), m_valid);
      check("locked",     int'(bus.locked),     m_locked ? 1 : 0);
      check("offset",     int'(bus.offset),     m_off);
      check("loss_cnt",   int'(bus.loss_cnt),   m_loss);
    end
  end

  // ---------------- stimulus helpers ----------------
  bit         bq [$];        // serial TX bits not yet packed into a word
  int         cur_delay = 0;
  int         gap_pct   = 0;
  bit         rec_on    = 1'b0;
  logic [7:0] rec [$];

  task automatic cyc(input logic [7:0] d, input bit en, input bit rs);
    bus.din    = d;
    bus.din_en = en;
    bus.resync = rs;
    @(posedge clk);
    #1;
    bus.resync = 1'b0;
  endtask

  task automatic drain();
    while (bq.size() >= 8) begin
      logic [7:0] w;
      for (int i = 7; i >= 0; i--) w[i] = bq.pop_front();
      if (gap_pct > 0 && int'($urandom_range(99)) < gap_pct) cyc(8'($urandom), 1'b0, 1'b0);
      cyc(w, 1'b1, 1'b0);
      if (rec_on && bus.dout_valid) rec.push_back(bus.dout);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) bq.push_back(b[i]);
    drain();
  endtask

  task automatic train(input int n);
    repeat (n) push_byte(PAT);
  endtask

  task automatic restart(input int d);
    bq.delete();
    cur_delay = d;
    repeat (d) bq.push_back(1'b0);
  endtask

  // Move the byte boundary by inserting filler bits into the serial stream
  task automatic set_delay(input int nd);
    int n;
    n = (nd - cur_delay + 8) % 8;
    repeat (n) bq.push_back(1'b0);
    cur_delay = nd;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    bus.din = 8'd0; bus.din_en = 1'b0; bus.resync = 1'b0;

    // Reset with random input activity
    repeat (3) cyc(8'($urandom), 1'b1, 1'b0);
    check("rst_dout",     int'(bus.dout),       0);
    check("rst_valid",    int'(bus.dout_valid), 0);
    check("rst_locked",   int'(bus.locked),     0);
    check("rst_offset",   int'(bus.offset),     0);
    check("rst_loss",     int'(bus.loss_cnt),   0);
    rst_n  = 1'b1;
    chk_on = 1'b1;
    repeat (10) cyc(8'h00, 1'b1, 1'b0);
    check("idle_locked", int'(bus.locked), 0);

    // 0xF0 delayed by 3 bits on the wire arrives as 0x1E words
    for (int i = 1; i <= 18; i++) begin
      cyc(8'h1E, 1'b1, 1'b0);
      if (i == 17) check("lock_early", int'(bus.locked), 0);
    end
    check("lock_time",   int'(bus.locked), 1);
    check("lock_offset", int'(bus.offset), 3);
    repeat (3) cyc(8'h1E, 1'b1, 1'b0);
    check("lock_dout",  int'(bus.dout),       8'hF0);
    check("lock_valid", int'(bus.dout_valid), 1);

    // Resync from lock, then a corrupted word in the middle of verification
    cyc(8'h00, 1'b1, 1'b1);
    check("resync_locked", int'(bus.locked),   0);
    check("resync_loss",   int'(bus.loss_cnt), 1);
    repeat (3) cyc(8'h00, 1'b1, 1'b0);
    repeat (8) cyc(8'h1E, 1'b1, 1'b0);
    cyc(8'h00, 1'b1, 1'b0);
    for (int i = 1; i <= 18; i++) begin
      cyc(8'h1E, 1'b1, 1'b0);
      if (i == 17) check("relock_early", int'(bus.locked), 0);
    end
    check("relock_time", int'(bus.locked), 1);

    // Sweep all bit delays; payload must come out byte-for-byte
    for (int d = 0; d < 8; d++) begin
      int found;
      cyc(8'h00, 1'b1, 1'b1);
      restart(d);
      train(LOCKN + 8);
      check("sweep_locked", int'(bus.locked), 1);
      check("sweep_offset", int'(bus.offset), d);
      rec.delete();
      rec_on = 1'b1;
      push_byte(8'h11); push_byte(8'h22); push_byte(8'h33); push_byte(8'h44);
      train(4);
      rec_on = 1'b0;
      found = 0;
      for (int i = 0; i + 3 < rec.size(); i++)
        if (rec[i] == 8'h11 && rec[i+1] == 8'h22 && rec[i+2] == 8'h33 && rec[i+3] == 8'h44)
          found = 1;
      check("sweep_data", found, 1);
    end

    // Asynchronous reset mid-operation clears everything at once
    rst_n = 1'b0;
    #1;
    check("arst_locked", int'(bus.locked),   0);
    check("arst_loss",   int'(bus.loss_cnt), 0);
    check("arst_offset", int'(bus.offset),   0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Lock at delay 3, then the stream slips to delay 2
    restart(3);
    train(30);
    check("slip_pre_offset", int'(bus.offset), 3);
    set_delay(2);
    train(40);
    check("slip_loss",   int'(bus.loss_cnt), 1);
    check("slip_offset", int'(bus.offset),   2);
    check("slip_locked", int'(bus.locked),   1);

    // DIN_EN toggling while locked (delay-2 training words are 0x3C)
    for (int i = 0; i < 12; i++) begin
      bit en;
      en = (i % 2 == 0);
      cyc(8'h3C, en, 1'b0);
      check("en_follow", int'(bus.dout_valid), en ? 1 : 0);
    end
    cyc(8'h3C, 1'b1, 1'b1);
    check("pulse_locked", int'(bus.locked),     0);
    check("pulse_valid",  int'(bus.dout_valid), 0);
    check("pulse_loss",   int'(bus.loss_cnt),   2);
    cyc(8'h3C, 1'b1, 1'b1);
    check("unlocked_resync_loss", int'(bus.loss_cnt), 2);

    // Drive the loss counter into saturation
    for (int it = 0; it < 260; it++) begin
      int b;
      b = 0;
      while (!bus.locked && b < 40) begin
        cyc(8'h3C, 1'b1, 1'b0);
        b++;
      end
      check("sat_lock", int'(bus.locked), 1);
      cyc(8'h3C, 1'b1, 1'b1);
      if (it == 251) check("sat_pre", int'(bus.loss_cnt), 254);
    end
    check("sat_loss", int'(bus.loss_cnt), 255);

    // Randomized traffic: payload, training, gaps, slips and resyncs
    gap_pct = 20;
    restart(int'($urandom_range(7)));
    for (int seg = 0; seg < 40; seg++) begin
      case ($urandom_range(3))
        0: repeat ($urandom_range(20, 5)) push_byte(8'($urandom));
        1: set_delay(int'($urandom_range(7)));
        default: train(int'($urandom_range(30, 10)));
      endcase
      if ($urandom_range(9) == 0) cyc(8'($urandom), 1'($urandom_range(1)), 1'b1);
    end

    chk_on = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
